// File: rtl/cvp14_mem_responder.sv
// Memory-side responder for the CVP14 external bus: word array, fixed-latency reads, write ack.
// Optional feature macro MEMRESP_STATS_EN adds saturating RdCount/WrCount request counters.
module cvp14_mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int RD_LAT     = 2
) (
    input  logic        Clk1,
    input  logic        Reset,
    input  logic [15:0] Addr,
    input  logic        RD,
    input  logic        WR,
    input  logic [15:0] WrData,
    output logic [15:0] RdData,
    output logic        RdValid,
    output logic        Ack,
    output logic        Err
`ifdef MEMRESP_STATS_EN
    ,
    output logic [15:0] RdCount,
    output logic [15:0] WrCount
`endif
);

    localparam int          DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [15:0] OOR_MASK = 16'hFFFF << DEPTH_LOG2;

    logic                  rd_acc_s;
    logic                  wr_acc_s;
    logic                  ill_s;
    logic                  oor_s;
    logic [DEPTH_LOG2-1:0] idx_s;

    logic [15:0] mem_q [DEPTH];
    logic [15:0] rdraw_q;

    logic v0_q, v0_d, e0_q, e0_d;
    logic wack0_q, wack0_d, werr0_q, werr0_d;
    logic ack_q, ack_d, err_q, err_d;

    logic [RD_LAT:1] v_q, e_q;
    logic [15:0]     d_q [1:RD_LAT];
    logic [RD_LAT:1] src_v_s, src_e_s;
    logic [15:0]     src_d_s [1:RD_LAT];

    assign rd_acc_s = RD & ~WR;
    assign wr_acc_s = WR & ~RD;
    assign ill_s    = RD & WR;
    assign oor_s    = |(Addr & OOR_MASK);
    assign idx_s    = Addr[DEPTH_LOG2-1:0];

    // Array is never cleared; the raw read word is captured every edge so a later write cannot leak into it.
    always_ff @(posedge Clk1) begin
        if (Reset && wr_acc_s && !oor_s) begin
            mem_q[idx_s] <= WrData;
        end
        rdraw_q <= mem_q[idx_s];
    end

    // Accept stage: classify the request sampled at this edge.
    always_comb begin
        v0_d    = rd_acc_s;
        e0_d    = rd_acc_s & oor_s;
        wack0_d = wr_acc_s & ~oor_s;
        werr0_d = (wr_acc_s & oor_s) | ill_s;
    end

    // Shift-pipeline inputs; stage 1 picks up the raw array word (or zero when out of range).
    always_comb begin
        src_v_s[1] = v0_q;
        src_e_s[1] = e0_q;
        src_d_s[1] = e0_q ? 16'h0000 : rdraw_q;
        for (int i = 2; i <= RD_LAT; i++) begin
            src_v_s[i] = v_q[i-1];
            src_e_s[i] = e_q[i-1];
            src_d_s[i] = d_q[i-1];
        end
        ack_d = wack0_q;
        err_d = werr0_q | (src_v_s[RD_LAT] & src_e_s[RD_LAT]);
    end

    // Data stages only load with a valid beat, so the last stage holds RdData between returns.
    always_ff @(posedge Clk1) begin
        if (!Reset) begin
            v0_q    <= 1'b0;
            e0_q    <= 1'b0;
            wack0_q <= 1'b0;
            werr0_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            v_q     <= '0;
            e_q     <= '0;
            for (int i = 1; i <= RD_LAT; i++) begin
                d_q[i] <= 16'h0000;
            end
        end else begin
            v0_q    <= v0_d;
            e0_q    <= e0_d;
            wack0_q <= wack0_d;
            werr0_q <= werr0_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            v_q     <= src_v_s;
            e_q     <= src_e_s & src_v_s;
            for (int i = 1; i <= RD_LAT; i++) begin
                if (src_v_s[i]) begin
                    d_q[i] <= src_d_s[i];
                end
            end
        end
    end

    assign RdData  = d_q[RD_LAT];
    assign RdValid = v_q[RD_LAT];
    assign Ack     = ack_q;
    assign Err     = err_q;

`ifdef MEMRESP_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (rd_acc_s && !oor_s && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end else begin
            rd_cnt_d = rd_cnt_q;
        end
        if (wr_acc_s && !oor_s && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
    end

    always_ff @(posedge Clk1) begin
        if (!Reset) begin
            rd_cnt_q <= 16'h0000;
            wr_cnt_q <= 16'h0000;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign RdCount = rd_cnt_q;
    assign WrCount = wr_cnt_q;
`endif

endmodule

// File: tb/tb_cvp14_mem_responder.sv
// Scoreboard bench for cvp14_mem_responder: stimulus pushes expected responses, a negedge monitor checks them.
// Counter checks are compiled in when MEMRESP_STATS_EN is defined.
module tb_cvp14_mem_responder;

    localparam int RD_LAT     = 2;
    localparam int DEPTH_LOG2 = 10;

    logic        Clk1   = 1'b0;
    logic        Reset  = 1'b0;
    logic [15:0] Addr   = 16'h0000;
    logic        RD     = 1'b0;
    logic        WR     = 1'b0;
    logic [15:0] WrData = 16'h0000;
    logic [15:0] RdData;
    logic        RdValid;
    logic        Ack;
    logic        Err;
`ifdef MEMRESP_STATS_EN
    logic [15:0] RdCount;
    logic [15:0] WrCount;
`endif

    cvp14_mem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .RD_LAT(RD_LAT)) dut (
        .Clk1    (Clk1),
        .Reset   (Reset),
        .Addr    (Addr),
        .RD      (RD),
        .WR      (WR),
        .WrData  (WrData),
        .RdData  (RdData),
        .RdValid (RdValid),
        .Ack     (Ack),
        .Err     (Err)
`ifdef MEMRESP_STATS_EN
        ,
        .RdCount (RdCount),
        .WrCount (WrCount)
`endif
    );

    always #5 Clk1 = ~Clk1;

    typedef struct {
        int          issue;
        int          due;
        bit          is_rd;
        logic [15:0] data;
        bit          ack;
        bit          err;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] ref_mem [int];
    int          cyc         = 0;
    bit          rst_at_edge = 1'b0;
    int          checks      = 0;
    int          errors      = 0;
    logic [15:0] hold_data   = 16'h0000;
    int          exp_rd_cnt  = 0;
    int          exp_wr_cnt  = 0;

    always @(posedge Clk1) begin
        cyc         <= cyc + 1;
        rst_at_edge <= Reset;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: after edge cyc, pop everything due at that edge and compare every output.
    always @(negedge Clk1) begin : monitor
        bit ev;
        bit ea;
        bit ee;
        if (cyc >= 1) begin
            ev = 1'b0;
            ea = 1'b0;
            ee = 1'b0;
            if (!rst_at_edge) begin
                for (int i = sb_q.size() - 1; i >= 0; i--) begin
                    if (sb_q[i].issue < cyc) sb_q.delete(i);
                end
                hold_data  = 16'h0000;
                exp_rd_cnt = 0;
                exp_wr_cnt = 0;
            end else begin
                for (int i = sb_q.size() - 1; i >= 0; i--) begin
                    if (sb_q[i].due == cyc) begin
                        if (sb_q[i].is_rd) begin
                            ev        = 1'b1;
                            hold_data = sb_q[i].data;
                        end
                        ea = ea | sb_q[i].ack;
                        ee = ee | sb_q[i].err;
                        sb_q.delete(i);
                    end
                end
                foreach (sb_q[i]) begin
                    if (sb_q[i].issue == cyc) begin
                        if (sb_q[i].is_rd && !sb_q[i].err) exp_rd_cnt++;
                        if (!sb_q[i].is_rd && sb_q[i].ack) exp_wr_cnt++;
                    end
                end
            end
            chk("RdValid", {15'h0000, RdValid}, {15'h0000, ev});
            chk("RdData",  RdData, hold_data);
            chk("Ack",     {15'h0000, Ack}, {15'h0000, ea});
            chk("Err",     {15'h0000, Err}, {15'h0000, ee});
`ifdef MEMRESP_STATS_EN
            chk("RdCount", RdCount, 16'(exp_rd_cnt));
            chk("WrCount", WrCount, 16'(exp_wr_cnt));
`endif
        end
    end

    // Drive one request for the next edge and record what it should produce.
    task automatic req(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        int   k;
        bit   oor;
        k       = cyc + 1;
        oor     = (a[15:DEPTH_LOG2] != '0);
        RD      = rd;
        WR      = wr;
        Addr    = a;
        WrData  = d;
        e.issue = k;
        e.due   = k + 1;
        e.is_rd = 1'b0;
        e.data  = 16'h0000;
        e.ack   = 1'b0;
        e.err   = 1'b0;
        if (rd && wr) begin
            e.err = 1'b1;
            sb_q.push_back(e);
        end else if (rd) begin
            e.due   = k + RD_LAT;
            e.is_rd = 1'b1;
            e.err   = oor;
            e.data  = oor ? 16'h0000 : ref_mem[int'(a)];
            sb_q.push_back(e);
        end else if (wr) begin
            e.ack = !oor;
            e.err = oor;
            sb_q.push_back(e);
            if (!oor) ref_mem[int'(a)] = d;
        end
        @(posedge Clk1);
        #1;
        RD = 1'b0;
        WR = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk1);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b0;
        RD    = 1'b0;
        WR    = 1'b0;
        idle(n);
        Reset = 1'b1;
    endtask

    initial begin
        idle(3);
        Reset = 1'b1;

        // Write then read on the next cycle.
        req(1'b0, 1'b1, 16'h0005, 16'hBEEF);
        req(1'b1, 1'b0, 16'h0005, 16'h0000);
        idle(4);

        // 16-word burst of writes followed by 16 back-to-back reads.
        for (int i = 0; i < 16; i++) req(1'b0, 1'b1, 16'h0040 + 16'(i), 16'h0100 + 16'(i));
        for (int i = 0; i < 16; i++) req(1'b1, 1'b0, 16'h0040 + 16'(i), 16'h0000);
        idle(4);

        // Illegal RD=WR=1 must not disturb Addr 5.
        req(1'b1, 1'b1, 16'h0005, 16'hDEAD);
        req(1'b1, 1'b0, 16'h0005, 16'h0000);
        idle(4);

        // Out-of-range write and read.
        req(1'b0, 1'b1, 16'hFFFF, 16'h1234);
        req(1'b1, 1'b0, 16'hFFFF, 16'h0000);
        idle(4);

        // Read before a write to the same word returns old data; RdValid and Ack coincide.
        req(1'b1, 1'b0, 16'h0040, 16'h0000);
        req(1'b0, 1'b1, 16'h0040, 16'hA5A5);
        req(1'b1, 1'b0, 16'h0040, 16'h0000);
        idle(4);

        // Reset with two reads in flight; array survives.
        req(1'b1, 1'b0, 16'h0041, 16'h0000);
        req(1'b1, 1'b0, 16'h0040, 16'h0000);
        do_reset(2);
        req(1'b1, 1'b0, 16'h0005, 16'h0000);
        idle(4);

        // Counter mix: 3 writes, 4 reads, 1 illegal, then reset.
        req(1'b0, 1'b1, 16'h0010, 16'h0001);
        req(1'b0, 1'b1, 16'h0011, 16'h0002);
        req(1'b0, 1'b1, 16'h0012, 16'h0003);
        req(1'b1, 1'b0, 16'h0010, 16'h0000);
        req(1'b1, 1'b0, 16'h0011, 16'h0000);
        req(1'b1, 1'b0, 16'h0012, 16'h0000);
        req(1'b1, 1'b0, 16'h0005, 16'h0000);
        req(1'b1, 1'b1, 16'h0013, 16'h0004);
        idle(5);
        do_reset(1);
        idle(3);

        chk("sb_drained", 16'(sb_q.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
